mux4x1_8bits_rr: RTL and testbench

- Counterpart of the 1x4 8-bit lane demux: merges four 8-bit byte lanes back into one 8-bit stream.
- Each input lane has a small FIFO. A round-robin arbiter drains the non-empty FIFOs, one byte per cycle.
- The output is registered and carries a valid/ready handshake plus the source-lane index.
- Sits at the lane-merge point of the PCIe physical-layer datapath, ahead of the serializer.

---
 rtl/mux4x1_8bits_rr_if.sv | 27 ++
 rtl/mux4x1_8bits_rr.sv | 110 +++++++++++
 tb/tb_mux4x1_8bits_rr.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mux4x1_8bits_rr_if.sv
// Lane-merge handshake bundle: four input byte lanes plus the merged output stream.
interface mux4x1_8bits_rr_if;
   logic       valid_in0, valid_in1, valid_in2, valid_in3;
   logic [7:0] data_in0, data_in1, data_in2, data_in3;
   logic       ready_in0, ready_in1, ready_in2, ready_in3;
   logic       out_ready;
   logic       valid_out;
   logic [7:0] data_out;
   logic [1:0] lane_out;
   logic [3:0] overflow;

   modport master (
      output valid_in0, valid_in1, valid_in2, valid_in3,
      output data_in0, data_in1, data_in2, data_in3,
      output out_ready,
      input  ready_in0, ready_in1, ready_in2, ready_in3,
      input  valid_out, data_out, lane_out, overflow
   );

   modport slave (
      input  valid_in0, valid_in1, valid_in2, valid_in3,
      input  data_in0, data_in1, data_in2, data_in3,
      input  out_ready,
      output ready_in0, ready_in1, ready_in2, ready_in3,
      output valid_out, data_out, lane_out, overflow
   );
endinterface

// File: rtl/mux4x1_8bits_rr.sv
// 4-to-1 byte-lane merger: per-lane FIFOs drained by a round-robin arbiter into a
// registered valid/ready output carrying the source lane index.
module mux4x1_8bits_rr #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input logic               clk,
   input logic               reset_L,
   mux4x1_8bits_rr_if.slave  bus
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [3:0]    vin;
   logic [7:0]    din [4];
   logic [7:0]    mem [4][DEPTH];
   logic [AW-1:0] wptr [4];
   logic [AW-1:0] rptr [4];
   logic [AW:0]   count [4];
   logic [3:0]    full, nonempty, push, pop;
   logic [1:0]    last, gnt, cand;
   logic          gnt_any, load;
   logic          valid_q;
   logic [7:0]    data_q;
   logic [1:0]    lane_q;
   logic [3:0]    ovf_q;

   always_comb begin
      vin    = {bus.valid_in3, bus.valid_in2, bus.valid_in1, bus.valid_in0};
      din[0] = bus.data_in0;
      din[1] = bus.data_in1;
      din[2] = bus.data_in2;
      din[3] = bus.data_in3;
      for (int unsigned i = 0; i < 4; i++) begin
         full[i]     = (count[i] == FULL_CNT);
         nonempty[i] = (count[i] != '0);
      end
      push = vin & ~full;
   end

   // Search last+1 .. last+4 (mod 4) so the most recently granted lane is tried last.
   always_comb begin
      load    = ~valid_q | bus.out_ready;
      gnt     = '0;
      gnt_any = 1'b0;
      cand    = '0;
      for (int unsigned k = 1; k <= 4; k++) begin
         cand = last + k[1:0];
         if (!gnt_any && nonempty[cand]) begin
            gnt     = cand;
            gnt_any = 1'b1;
         end
      end
      pop = (load && gnt_any) ? (4'b0001 << gnt) : '0;
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < 4; i++)
         if (push[i]) mem[i][wptr[i]] <= din[i];
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         for (int unsigned i = 0; i < 4; i++) begin
            wptr[i]  <= '0;
            rptr[i]  <= '0;
            count[i] <= '0;
         end
         ovf_q <= '0;
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (push[i]) wptr[i] <= wptr[i] + AW'(1);
            if (pop[i])  rptr[i] <= rptr[i] + AW'(1);
            if (push[i] && !pop[i])
               count[i] <= count[i] + (AW+1)'(1);
            else if (!push[i] && pop[i])
               count[i] <= count[i] - (AW+1)'(1);
            if (vin[i] && full[i]) ovf_q[i] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         lane_q  <= '0;
         last    <= 2'd3;
      end else if (load) begin
         if (gnt_any) begin
            valid_q <= 1'b1;
            data_q  <= mem[gnt][rptr[gnt]];
            lane_q  <= gnt;
            last    <= gnt;
         end else begin
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.ready_in0 = ~full[0];
   assign bus.ready_in1 = ~full[1];
   assign bus.ready_in2 = ~full[2];
   assign bus.ready_in3 = ~full[3];
   assign bus.valid_out = valid_q;
   assign bus.data_out  = data_q;
   assign bus.lane_out  = lane_q;
   assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_mux4x1_8bits_rr.sv
// Directed bench for mux4x1_8bits_rr: vector table for basic merge, hand sequences for stall/fairness/reset.
module tb_mux4x1_8bits_rr;

   logic clk = 1'b0;
   logic reset_L = 1'b0;
   int   errors = 0;
   int   checks = 0;

   mux4x1_8bits_rr_if bus ();

   mux4x1_8bits_rr #(.DEPTH(4), .AW(2)) dut (
      .clk     (clk),
      .reset_L (reset_L),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] vin;
      logic [7:0] d0, d1, d2, d3;
      logic       ordy;
      logic       evo;
      logic [7:0] edo;
      logic [1:0] elane;
      logic [3:0] erdy;
      logic [3:0] eov;
   } vec_t;

   vec_t vecs [16];

   function automatic vec_t mk(logic [3:0] vin, logic [7:0] d0, logic [7:0] d1,
                               logic [7:0] d2, logic [7:0] d3, logic ordy, logic evo,
                               logic [7:0] edo, logic [1:0] elane, logic [3:0] erdy,
                               logic [3:0] eov);
      vec_t v;
      v.vin = vin; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3; v.ordy = ordy;
      v.evo = evo; v.edo = edo; v.elane = elane; v.erdy = erdy; v.eov = eov;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string name, input logic evo, input logic [7:0] edo,
                          input logic [1:0] elane, input logic [3:0] erdy, input logic [3:0] eov);
      chk({name, ".valid_out"}, 32'(bus.valid_out), 32'(evo));
      chk({name, ".data_out"},  32'(bus.data_out),  32'(edo));
      chk({name, ".lane_out"},  32'(bus.lane_out),  32'(elane));
      chk({name, ".ready_in"},
          32'({bus.ready_in3, bus.ready_in2, bus.ready_in1, bus.ready_in0}), 32'(erdy));
      chk({name, ".overflow"},  32'(bus.overflow),  32'(eov));
   endtask

   task automatic drive(input logic [3:0] vin, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3, input logic ordy);
      bus.valid_in0 = vin[0]; bus.valid_in1 = vin[1];
      bus.valid_in2 = vin[2]; bus.valid_in3 = vin[3];
      bus.data_in0 = d0; bus.data_in1 = d1; bus.data_in2 = d2; bus.data_in3 = d3;
      bus.out_ready = ordy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string name);
      drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      reset_L = 1'b0;
      step();
      chk_out(name, 1'b0, 8'h00, 2'd0, 4'b1111, 4'b0000);
      reset_L = 1'b1;
   endtask

   initial begin
      // Test 1: one byte on each lane, drained in lane order.
      vecs[0]  = mk(4'b1111, 8'h10, 8'h21, 8'h32, 8'h43, 1, 0, 8'h00, 2'd0, 4'b1111, 4'h0);
      vecs[1]  = mk(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h10, 2'd0, 4'b1111, 4'h0);
      vecs[2]  = mk(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h21, 2'd1, 4'b1111, 4'h0);
      vecs[3]  = mk(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h32, 2'd2, 4'b1111, 4'h0);
      vecs[4]  = mk(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h43, 2'd3, 4'b1111, 4'h0);
      vecs[5]  = mk(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h43, 2'd3, 4'b1111, 4'h0);
      // Test 2: streaming lane 2, pointers wrap, ready stays high.
      vecs[6]  = mk(4'b0100, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h43, 2'd3, 4'b1111, 4'h0);
      for (int k = 1; k < 8; k++)
         vecs[6+k] = mk(4'b0100, 8'h00, 8'h00, 8'(k), 8'h00, 1, 1, 8'(k-1), 2'd2, 4'b1111, 4'h0);
      vecs[14] = mk(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h07, 2'd2, 4'b1111, 4'h0);
      vecs[15] = mk(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h07, 2'd2, 4'b1111, 4'h0);

      do_reset("reset1");
      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].vin, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3, vecs[i].ordy);
         step();
         chk_out($sformatf("vec%0d", i), vecs[i].evo, vecs[i].edo, vecs[i].elane,
                 vecs[i].erdy, vecs[i].eov);
      end

      // Test 3: stall with lane 1 filling; one byte sits in the output register.
      do_reset("reset3");
      drive(4'b0010, 8'h00, 8'hA0, 8'h00, 8'h00, 1'b0);
      step();
      chk_out("stall_e0", 1'b0, 8'h00, 2'd0, 4'b1111, 4'h0);
      for (int k = 1; k < 5; k++) begin
         drive(4'b0010, 8'h00, 8'(8'hA0 + k), 8'h00, 8'h00, 1'b0);
         step();
         chk_out($sformatf("stall_e%0d", k), 1'b1, 8'hA0, 2'd1,
                 (k == 4) ? 4'b1101 : 4'b1111, 4'h0);
      end
      drive(4'b0010, 8'h00, 8'hA5, 8'h00, 8'h00, 1'b0);
      step();
      chk_out("stall_drop", 1'b1, 8'hA0, 2'd1, 4'b1101, 4'b0010);
      drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      for (int k = 1; k < 5; k++) begin
         step();
         chk_out($sformatf("drain_%0d", k), 1'b1, 8'(8'hA0 + k), 2'd1, 4'b1111, 4'b0010);
      end
      step();
      chk_out("drain_end", 1'b0, 8'hA4, 2'd1, 4'b1111, 4'b0010);

      // Test 4: lanes 0 and 3 both backlogged must alternate.
      do_reset("reset4");
      for (int k = 0; k < 4; k++) begin
         drive(4'b1001, 8'(k), 8'h00, 8'h00, 8'(8'h30 + k), 1'b0);
         step();
      end
      chk_out("fair_pre", 1'b1, 8'h00, 2'd0, 4'b0111, 4'h0);
      drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      for (int k = 0; k < 7; k++) begin
         step();
         if (k % 2 == 0)
            chk_out($sformatf("fair_%0d", k), 1'b1, 8'(8'h30 + k/2), 2'd3, 4'b1111, 4'h0);
         else
            chk_out($sformatf("fair_%0d", k), 1'b1, 8'(1 + k/2), 2'd0, 4'b1111, 4'h0);
      end
      step();
      chk_out("fair_end", 1'b0, 8'h33, 2'd3, 4'b1111, 4'h0);

      // Test 5: asynchronous reset in the middle of a drain.
      do_reset("reset5");
      for (int k = 0; k < 6; k++) begin
         drive(4'b0001, 8'(8'hC0 + k), 8'h00, 8'h00, 8'h00, 1'b0);
         step();
      end
      chk_out("rst_pre", 1'b1, 8'hC0, 2'd0, 4'b1110, 4'b0001);
      drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      step();
      chk_out("rst_mid", 1'b1, 8'hC1, 2'd0, 4'b1111, 4'b0001);
      #2 reset_L = 1'b0;
      #1;
      chk_out("rst_async", 1'b0, 8'h00, 2'd0, 4'b1111, 4'b0000);
      #1 reset_L = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk_out($sformatf("rst_after%0d", k), 1'b0, 8'h00, 2'd0, 4'b1111, 4'b0000);
      end

      // Test 6: full lane popped while a push arrives: push rejected, ready returns.
      do_reset("reset6");
      for (int k = 0; k < 5; k++) begin
         drive(4'b1000, 8'h00, 8'h00, 8'h00, 8'(8'hB0 + k), 1'b0);
         step();
      end
      chk_out("full_pre", 1'b1, 8'hB0, 2'd3, 4'b0111, 4'h0);
      drive(4'b1000, 8'h00, 8'h00, 8'h00, 8'hEE, 1'b1);
      step();
      chk_out("full_popush", 1'b1, 8'hB1, 2'd3, 4'b1111, 4'b1000);
      drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      for (int k = 2; k < 5; k++) begin
         step();
         chk_out($sformatf("full_drain%0d", k), 1'b1, 8'(8'hB0 + k), 2'd3, 4'b1111, 4'b1000);
      end
      step();
      chk_out("full_end", 1'b0, 8'hB4, 2'd3, 4'b1111, 4'b1000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
